// File: rtl/cnn_mac_pipe_sat.sv
// Pipelined signed multiply-accumulate with round-half-up, arithmetic right
// shift and saturation. One beat per cycle, valid/ready on both sides, and a
// single global stall driven by the output register.
module cnn_mac_pipe_sat #(
  parameter int DIN0_WIDTH = 14,
  parameter int DIN1_WIDTH = 9,
  parameter int ACC_WIDTH  = 32,
  parameter int DOUT_WIDTH = 16,
  parameter int MUL_STAGES = 2,
  parameter int SHIFT      = 8
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIN0_WIDTH-1:0] din0,
  input  logic [DIN1_WIDTH-1:0] din1,
  input  logic                  in_first,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DOUT_WIDTH-1:0] dout,
  output logic                  dout_ovf,
  output logic                  busy
);

  localparam int PW   = DIN0_WIDTH + DIN1_WIDTH;
  localparam int LAST = MUL_STAGES - 1;

  // Rounding constant: half of one output LSB after the shift.
  localparam logic signed [ACC_WIDTH:0] RND =
    (SHIFT > 0) ? (ACC_WIDTH+1)'(64'sd1 <<< ((SHIFT > 0) ? (SHIFT - 1) : 0))
                : (ACC_WIDTH+1)'(64'sd0);

  // Output range limits.
  localparam logic signed [DOUT_WIDTH-1:0] DMAX = {1'b0, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [DOUT_WIDTH-1:0] DMIN = {1'b1, {(DOUT_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH:0]    RMAX = (ACC_WIDTH+1)'(DMAX);
  localparam logic signed [ACC_WIDTH:0]    RMIN = (ACC_WIDTH+1)'(DMIN);

  // Operand register stage
  logic                         iv_q, if_q, il_q;
  logic signed [DIN0_WIDTH-1:0] a_q;
  logic signed [DIN1_WIDTH-1:0] b_q;

  // Product pipeline
  logic [MUL_STAGES-1:0]        pv_q, pf_q, pl_q;
  logic signed [PW-1:0]         pp_q [MUL_STAGES];

  // Accumulator and output
  logic signed [ACC_WIDTH-1:0]  acc_q;
  logic signed [ACC_WIDTH-1:0]  acc_d;
  logic                         sum_open_q;
  logic                         out_valid_q;
  logic [DOUT_WIDTH-1:0]        dout_q;
  logic                         ovf_q;

  logic                         adv;
  logic signed [PW-1:0]         prod_c;
  logic signed [ACC_WIDTH-1:0]  p_ext;
  logic signed [ACC_WIDTH:0]    sum_r;
  logic signed [ACC_WIDTH:0]    shr_r;
  logic                         sat_hi, sat_lo;
  logic [DOUT_WIDTH-1:0]        dout_d;
  logic                         tv, tf, tl;

  // Whole pipeline advances together unless a result is waiting downstream.
  assign adv      = ~(out_valid_q & ~out_ready);
  assign in_ready = adv;

  assign prod_c = a_q * b_q;

  assign tv = pv_q[LAST];
  assign tf = pf_q[LAST];
  assign tl = pl_q[LAST];

  // Accumulate, round, shift and clip for the beat leaving the product pipe.
  always_comb begin
    p_ext  = ACC_WIDTH'(pp_q[LAST]);
    acc_d  = tf ? p_ext : (acc_q + p_ext);
    sum_r  = (ACC_WIDTH+1)'(acc_d) + RND;
    shr_r  = sum_r >>> SHIFT;
    sat_hi = (shr_r > RMAX);
    sat_lo = (shr_r < RMIN);
    if (sat_hi) begin
      dout_d = DMAX;
    end else if (sat_lo) begin
      dout_d = DMIN;
    end else begin
      dout_d = shr_r[DOUT_WIDTH-1:0];
    end
  end

  // Register the accepted operands and their framing flags.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      iv_q <= 1'b0;
      if_q <= 1'b0;
      il_q <= 1'b0;
      a_q  <= '0;
      b_q  <= '0;
    end else if (adv) begin
      iv_q <= in_valid;
      if_q <= in_valid & in_first;
      il_q <= in_valid & in_last;
      if (in_valid) begin
        a_q <= din0;
        b_q <= din1;
      end
    end
  end

  // Carry the product and its flags through MUL_STAGES registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      pv_q <= '0;
      pf_q <= '0;
      pl_q <= '0;
      for (int i = 0; i < MUL_STAGES; i++) pp_q[i] <= '0;
    end else if (adv) begin
      pv_q[0] <= iv_q;
      pf_q[0] <= if_q;
      pl_q[0] <= il_q;
      pp_q[0] <= prod_c;
      for (int i = 1; i < MUL_STAGES; i++) begin
        pv_q[i] <= pv_q[i-1];
        pf_q[i] <= pf_q[i-1];
        pl_q[i] <= pl_q[i-1];
        pp_q[i] <= pp_q[i-1];
      end
    end
  end

  // Update the running sum and track whether a group is open.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      acc_q      <= '0;
      sum_open_q <= 1'b0;
    end else if (adv && tv) begin
      acc_q <= acc_d;
      if (tl) begin
        sum_open_q <= 1'b0;
      end else if (tf) begin
        sum_open_q <= 1'b1;
      end
    end
  end

  // Load a finished result, or clear the output slot once it has been taken.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      ovf_q       <= 1'b0;
    end else if (adv) begin
      if (tv && tl) begin
        out_valid_q <= 1'b1;
        dout_q      <= dout_d;
        ovf_q       <= sat_hi | sat_lo;
      end else begin
        out_valid_q <= 1'b0;
        dout_q      <= '0;
        ovf_q       <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign dout      = dout_q;
  assign dout_ovf  = ovf_q;
  assign busy      = iv_q | (|pv_q) | out_valid_q | sum_open_q;

endmodule

// File: tb/tb_cnn_mac_pipe_sat.sv
// Self-checking bench for cnn_mac_pipe_sat with default parameters.
// A behavioural scoreboard computes every result from accepted beats.
module tb_cnn_mac_pipe_sat;

  logic        ap_clk = 1'b0;
  logic        ap_rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [13:0] din0 = '0;
  logic [8:0]  din1 = '0;
  logic        in_first = 1'b0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] dout;
  logic        dout_ovf;
  logic        busy;

  cnn_mac_pipe_sat dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .din0     (din0),
    .din1     (din1),
    .in_first (in_first),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .dout     (dout),
    .dout_ovf (dout_ovf),
    .busy     (busy)
  );

  always #5 ap_clk = ~ap_clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit rand_en  = 1'b0;

  typedef struct {
    longint d;
    bit     o;
  } res_t;
  res_t   exp_q[$];
  longint macc = 0;
  int     n_results = 0;
  longint last_dout = 0;
  bit     last_ovf = 1'b0;
  longint cyc = 0;
  longint res_cyc = 0;
  longint prev_res_cyc = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
  endtask

  // Reference result from the sum: round half up, shift by 8, clip to 16 bits.
  function automatic res_t ref_result(input longint s);
    res_t   r;
    longint q;
    q = (s + 128) >>> 8;
    if (q > 32767) begin r.d = 32767; r.o = 1'b1; end
    else if (q < -32768) begin r.d = -32768; r.o = 1'b1; end
    else begin r.d = q; r.o = 1'b0; end
    return r;
  endfunction

  // Scoreboard: sampled mid-cycle, where handshakes are settled for the next edge.
  always @(negedge ap_clk) begin
    res_t   e;
    longint p;
    cyc++;
    if (!ap_rst_n) begin
      macc = 0;
      exp_q.delete();
    end else begin
      if (in_valid && in_ready) begin
        p = longint'($signed(din0)) * longint'($signed(din1));
        macc = in_first ? p : (macc + p);
        macc = longint'(int'(macc));
        if (in_last) exp_q.push_back(ref_result(macc));
      end
      if (out_valid && out_ready) begin
        n_results++;
        prev_res_cyc = res_cyc;
        res_cyc = cyc;
        last_dout = longint'($signed(dout));
        last_ovf = dout_ovf;
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("result_dout", longint'($signed(dout)), e.d);
          chk("result_ovf", longint'(dout_ovf), longint'(e.o));
          $display("result %0d: dout=%0d ovf=%0d", n_results, $signed(dout), dout_ovf);
        end
      end
    end
  end

  // Present one beat and hold it until accepted; called just after a rising edge.
  task automatic send(input int a, input int b, input bit f, input bit l);
    bit rdy;
    int cnt;
    din0 = 14'(a);
    din1 = 9'(b);
    in_first = f;
    in_last = l;
    in_valid = 1'b1;
    cnt = 0;
    rdy = 1'b0;
    do begin
      if (rand_en) out_ready = ($urandom_range(0, 3) != 0);
      @(negedge ap_clk);
      rdy = in_ready;
      @(posedge ap_clk);
      #1;
      cnt++;
    end while (!rdy && cnt < 200);
    if (!rdy) chk("send_timeout", 0, 1);
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic drain();
    int cnt;
    out_ready = 1'b1;
    cnt = 0;
    while (busy && cnt < 500) begin
      @(posedge ap_clk);
      #1;
      cnt++;
    end
    chk("drain_busy", longint'(busy), 0);
  endtask

  typedef struct {
    int a;
    int b;
    int exp_d;
    bit exp_o;
  } vec_t;
  vec_t tbl[10];

  initial begin
    int lat;
    int n0;
    res_t rr;

    tbl[0] = '{100, -3, -1, 1'b0};
    tbl[1] = '{1000, 200, 781, 1'b0};
    tbl[2] = '{8191, 255, 8159, 1'b0};
    tbl[3] = '{-8192, -256, 8192, 1'b0};
    tbl[4] = '{-8192, 255, -8160, 1'b0};
    tbl[5] = '{0, 0, 0, 1'b0};
    tbl[6] = '{127, 1, 0, 1'b0};
    tbl[7] = '{128, 1, 1, 1'b0};
    tbl[8] = '{-128, 1, 0, 1'b0};
    tbl[9] = '{-129, 1, -1, 1'b0};

    // Reset and check the idle state.
    repeat (3) @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    chk("reset_in_ready", longint'(in_ready), 1);
    chk("reset_out_valid", longint'(out_valid), 0);
    chk("reset_dout", longint'(dout), 0);
    chk("reset_ovf", longint'(dout_ovf), 0);
    chk("reset_busy", longint'(busy), 0);

    // Single term and latency.
    send(100, -3, 1'b1, 1'b1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge ap_clk);
      #1;
      lat++;
    end
    chk("latency", lat, 3);
    chk("single_dout", longint'($signed(dout)), -1);
    chk("single_ovf", longint'(dout_ovf), 0);
    drain();

    // Table of single-term groups.
    foreach (tbl[i]) begin
      n0 = n_results;
      send(tbl[i].a, tbl[i].b, 1'b1, 1'b1);
      drain();
      chk("table_count", n_results - n0, 1);
      chk("table_dout", last_dout, tbl[i].exp_d);
      chk("table_ovf", longint'(last_ovf), longint'(tbl[i].exp_o));
    end

    // Four-beat sum.
    n0 = n_results;
    for (int i = 0; i < 4; i++) send(8191, 255, i == 0, i == 3);
    drain();
    chk("four_count", n_results - n0, 1);
    chk("four_dout", last_dout, 32636);
    chk("four_ovf", longint'(last_ovf), 0);

    // Positive and negative saturation.
    for (int i = 0; i < 8; i++) send(-8192, -256, i == 0, i == 7);
    drain();
    chk("satp_dout", last_dout, 32767);
    chk("satp_ovf", longint'(last_ovf), 1);
    for (int i = 0; i < 8; i++) send(-8192, 255, i == 0, i == 7);
    drain();
    chk("satn_dout", last_dout, -32768);
    chk("satn_ovf", longint'(last_ovf), 1);

    // Back-pressure: three results queued behind a held output.
    n0 = n_results;
    out_ready = 1'b0;
    send(2560, 1, 1'b1, 1'b1);
    send(5120, 1, 1'b1, 1'b1);
    send(7680, 1, 1'b1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(posedge ap_clk);
      #1;
      chk("stall_in_ready", longint'(in_ready), 0);
      chk("stall_out_valid", longint'(out_valid), 1);
      chk("stall_dout", longint'($signed(dout)), 10);
    end
    drain();
    chk("stall_count", n_results - n0, 3);
    chk("stall_last", last_dout, 30);

    // Reset in the middle of an open sum.
    send(1000, 100, 1'b1, 1'b0);
    send(1000, 100, 1'b0, 1'b0);
    chk("midsum_busy", longint'(busy), 1);
    ap_rst_n = 1'b0;
    #1;
    chk("rst_busy", longint'(busy), 0);
    chk("rst_out_valid", longint'(out_valid), 0);
    @(posedge ap_clk);
    @(posedge ap_clk);
    #1 ap_rst_n = 1'b1;
    n0 = n_results;
    send(1000, 200, 1'b1, 1'b1);
    drain();
    chk("post_rst_count", n_results - n0, 1);
    chk("post_rst_dout", last_dout, 781);

    // Group boundary on consecutive cycles.
    n0 = n_results;
    send(256, 10, 1'b1, 1'b0);
    send(256, 5, 1'b0, 1'b1);
    send(256, 7, 1'b1, 1'b1);
    drain();
    chk("adj_count", n_results - n0, 2);
    chk("adj_b_dout", last_dout, 7);
    chk("adj_spacing", res_cyc - prev_res_cyc, 1);

    // Randomized beats, framing and back-pressure.
    rand_en = 1'b1;
    for (int i = 0; i < 400; i++) begin
      send(int'($urandom_range(0, 16383)) - 8192,
           int'($urandom_range(0, 511)) - 256,
           $urandom_range(0, 3) == 0,
           (i == 399) || ($urandom_range(0, 3) == 0));
    end
    rand_en = 1'b0;
    drain();
    chk("random_leftover", exp_q.size(), 0);

    // Model sanity on the clip function boundary values.
    rr = ref_result(longint'(32767) * 256);
    chk("ref_edge", rr.d, 32767);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
